mst_rx_post: RTL and testbench

- Receive-side post-buffer for the FT601 master FIFO bus; the host-to-FPGA counterpart of the transmit pre-fetch stage.
- Captures 36-bit words (32 data + 4 byte-enable) read from the bus into four small per-channel buffers, selected by the bus FSM's current channel.
- Drains the active channel to the internal loop-back FIFO (loop-back mode) or to a per-channel incrementing-pattern checker (streaming mode).
- Raises per-channel almost-full so the bus FSM stops reading in time.

---
 rtl/mst_rx_post_pkg.sv | 13 +
 rtl/mst_rx_chbuf.sv | 104 ++++++++++
 rtl/mst_rx_post.sv | 121 ++++++++++++
 tb/tb_mst_rx_post.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mst_rx_post_pkg.sv
// mst_rx_post_pkg
//   Shared constants for the FT601 receive post-buffer: channel count,
//   byte-enable field geometry, the all-bytes-valid pattern and the
//   width of the saturating mismatch counter.
package mst_rx_post_pkg;

    localparam int NCH      = 4;            // bus channels
    localparam int CH_W     = 2;            // channel select width
    localparam int BE_W     = 4;            // byte enables live in [WIDTH-1:WIDTH-BE_W]
    localparam logic [BE_W-1:0] BE_FULL = 4'hf;
    localparam int ERRCNT_W = 16;

endpackage

// File: rtl/mst_rx_chbuf.sv
// mst_rx_chbuf
//   One receive channel: a LENGTH-deep word buffer with write pointer and
//   fill length, almost-full/not-empty/sticky-overflow flags, and the
//   incrementing-pattern checker's expected counter.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   cap_i        capture din_i this cycle (dropped and flagged if full)
//   pop_i        consume the head word (caller guarantees non-empty)
//   chk_i        pop is in streaming mode: compare head against expected
//   clr_i        clear overflow flag and expected counter
//   din_i        captured word {byte enables, data}
//   head_o       oldest buffered word
//   nempt_o      buffer holds at least one word
//   afull_o      buffer holds LENGTH-2 words or more
//   ovf_o        sticky overflow
//   mism_o       checker mismatch on this cycle's streaming pop
module mst_rx_chbuf
    import mst_rx_post_pkg::*;
#(
    parameter int ADDRBIT = 2,
    parameter int LENGTH  = 4,
    parameter int WIDTH   = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_i,
    input  logic             pop_i,
    input  logic             chk_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic             nempt_o,
    output logic             afull_o,
    output logic             ovf_o,
    output logic             mism_o
);

    localparam int DW = WIDTH - BE_W;
    localparam logic [ADDRBIT:0] FULL_LEN  = (ADDRBIT+1)'(LENGTH);
    localparam logic [ADDRBIT:0] AFULL_LEN = (ADDRBIT+1)'(LENGTH - 2);

    logic [WIDTH-1:0]   mem_q [LENGTH];
    logic [ADDRBIT-1:0] wrptr_q, wrptr_d, rdptr;
    logic [ADDRBIT:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic [DW-1:0]      exp_q, exp_d;
    logic               wr, match;

    always_comb begin
        wr    = cap_i && (len_q < FULL_LEN);
        // Read pointer is derived; at full length the low bits are zero so it
        // correctly lands on the write pointer.
        rdptr  = wrptr_q - len_q[ADDRBIT-1:0];
        head_o = mem_q[rdptr];

        wrptr_d = wr ? wrptr_q + 1'b1 : wrptr_q;

        len_d = len_q;
        if (wr && !pop_i)
            len_d = len_q + 1'b1;
        else if (!wr && pop_i)
            len_d = len_q - 1'b1;

        ovf_d = ovf_q;
        if (clr_i)
            ovf_d = 1'b0;
        else if (cap_i && !wr)
            ovf_d = 1'b1;

        match  = (head_o == {BE_FULL, exp_q});
        mism_o = chk_i && !match;

        // On mismatch the checker resyncs to the received value so a single
        // glitch counts once rather than for every following word.
        exp_d = exp_q;
        if (clr_i)
            exp_d = '0;
        else if (chk_i)
            exp_d = match ? exp_q + 1'b1 : head_o[DW-1:0] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LENGTH; i++)
                mem_q[i] <= '0;
            wrptr_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            exp_q   <= '0;
        end else begin
            if (wr)
                mem_q[wrptr_q] <= din_i;
            wrptr_q <= wrptr_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            exp_q   <= exp_d;
        end
    end

    assign nempt_o = (len_q != '0);
    assign afull_o = (len_q >= AFULL_LEN);
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/mst_rx_post.sv
// mst_rx_post
//   Receive post-buffer for the FT601 master FIFO bus. Words read from the
//   bus are captured into the current channel's buffer; the active channel
//   drains either to the internal loop-back FIFO or to a pattern checker.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   rxf_n, rd_n          bus data-available and read strobe (active low)
//   postena              drain enable
//   postmod              1 streaming/check, 0 loop-back
//   postchn              active channel
//   postdin              bus word {byte enables, data}
//   postafull            per-channel almost full
//   postnempt            per-channel not empty
//   postovf              per-channel sticky overflow
//   ififowr, ififodat    registered loop-back FIFO write
//   iffull               per-channel loop-back FIFO full
//   chkclr               clear checker state, sticky flags and counter
//   chkerr               per-channel sticky pattern error
//   errcnt               saturating total mismatch count
module mst_rx_post
    import mst_rx_post_pkg::*;
#(
    parameter int ADDRBIT = 2,
    parameter int LENGTH  = 4,
    parameter int WIDTH   = 36
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rxf_n,
    input  logic                rd_n,
    input  logic                postena,
    input  logic                postmod,
    input  logic [CH_W-1:0]     postchn,
    input  logic [WIDTH-1:0]    postdin,
    output logic [NCH-1:0]      postafull,
    output logic [NCH-1:0]      postnempt,
    output logic [NCH-1:0]      postovf,
    output logic                ififowr,
    input  logic [NCH-1:0]      iffull,
    output logic [WIDTH-1:0]    ififodat,
    input  logic                chkclr,
    output logic [NCH-1:0]      chkerr,
    output logic [ERRCNT_W-1:0] errcnt
);

    logic                cap, pop;
    logic [NCH-1:0]      cap_ch, pop_ch, chk_ch, mism_ch;
    logic [NCH-1:0]      nempt_w, afull_w, ovf_w;
    logic [WIDTH-1:0]    head_w [NCH];
    logic [WIDTH-1:0]    head_sel;

    logic                ififowr_q, ififowr_d;
    logic [WIDTH-1:0]    ififodat_q, ififodat_d;
    logic [NCH-1:0]      chkerr_q, chkerr_d;
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

    assign cap      = !rd_n && !rxf_n;
    assign pop      = postena && nempt_w[postchn] && (postmod || !iffull[postchn]);
    assign head_sel = head_w[postchn];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign cap_ch[c] = cap && (postchn == CH_W'(c));
        assign pop_ch[c] = pop && (postchn == CH_W'(c));
        assign chk_ch[c] = pop_ch[c] && postmod;

        mst_rx_chbuf #(
            .ADDRBIT (ADDRBIT),
            .LENGTH  (LENGTH),
            .WIDTH   (WIDTH)
        ) u_chbuf (
            .clk     (clk),
            .rst_n   (rst_n),
            .cap_i   (cap_ch[c]),
            .pop_i   (pop_ch[c]),
            .chk_i   (chk_ch[c]),
            .clr_i   (chkclr),
            .din_i   (postdin),
            .head_o  (head_w[c]),
            .nempt_o (nempt_w[c]),
            .afull_o (afull_w[c]),
            .ovf_o   (ovf_w[c]),
            .mism_o  (mism_ch[c])
        );
    end

    always_comb begin
        ififowr_d  = pop && !postmod;
        ififodat_d = ififowr_d ? head_sel : ififodat_q;

        chkerr_d = chkclr ? '0 : (chkerr_q | mism_ch);

        errcnt_d = errcnt_q;
        if (chkclr)
            errcnt_d = '0;
        else if ((|mism_ch) && (errcnt_q != '1))
            errcnt_d = errcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ififowr_q  <= 1'b0;
            ififodat_q <= '0;
            chkerr_q   <= '0;
            errcnt_q   <= '0;
        end else begin
            ififowr_q  <= ififowr_d;
            ififodat_q <= ififodat_d;
            chkerr_q   <= chkerr_d;
            errcnt_q   <= errcnt_d;
        end
    end

    assign postafull = afull_w;
    assign postnempt = nempt_w;
    assign postovf   = ovf_w;
    assign ififowr   = ififowr_q;
    assign ififodat  = ififodat_q;
    assign chkerr    = chkerr_q;
    assign errcnt    = errcnt_q;

endmodule

// File: tb/tb_mst_rx_post.sv
// tb_mst_rx_post
//   Directed bench for mst_rx_post. Loop-back words expected on the internal
//   FIFO port are queued as they are scheduled; a negedge monitor pops and
//   compares every ififowr beat. Flags and counters are checked inline.
module tb_mst_rx_post;

    localparam int ADDRBIT = 2;
    localparam int LENGTH  = 4;
    localparam int WIDTH   = 36;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rxf_n, rd_n, postena, postmod, chkclr;
    logic [1:0]        postchn;
    logic [WIDTH-1:0]  postdin;
    logic [3:0]        postafull, postnempt, postovf, iffull, chkerr;
    logic              ififowr;
    logic [WIDTH-1:0]  ififodat;
    logic [15:0]       errcnt;

    logic [WIDTH-1:0]  sb_q [$];
    int unsigned       n_vec = 0;
    int unsigned       n_err = 0;
    logic [5:0]        pat;

    always #5 clk = ~clk;

    mst_rx_post #(
        .ADDRBIT (ADDRBIT),
        .LENGTH  (LENGTH),
        .WIDTH   (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxf_n     (rxf_n),
        .rd_n      (rd_n),
        .postena   (postena),
        .postmod   (postmod),
        .postchn   (postchn),
        .postdin   (postdin),
        .postafull (postafull),
        .postnempt (postnempt),
        .postovf   (postovf),
        .ififowr   (ififowr),
        .iffull    (iffull),
        .ififodat  (ififodat),
        .chkclr    (chkclr),
        .chkerr    (chkerr),
        .errcnt    (errcnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every loop-back beat must match the oldest queued word.
    always @(negedge clk) begin
        if (ififowr === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL ififowr: got beat %0h, expected no write", ififodat);
            end else begin
                check("ififodat", 64'(ififodat), 64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, vectors=%0d", n_vec);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [1:0] ch, input logic [WIDTH-1:0] d);
        postchn = ch;
        postdin = d;
        rd_n    = 1'b0;
        rxf_n   = 1'b0;
        step();
        rd_n    = 1'b1;
        rxf_n   = 1'b1;
    endtask

    task automatic drain(input logic [1:0] ch, input int n);
        postchn = ch;
        postena = 1'b1;
        repeat (n) step();
        postena = 1'b0;
    endtask

    task automatic pulse_clr();
        chkclr = 1'b1;
        step();
        chkclr = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        rxf_n   = 1'b1;
        rd_n    = 1'b1;
        postena = 1'b0;
        postmod = 1'b0;
        postchn = 2'd0;
        postdin = '0;
        iffull  = '0;
        chkclr  = 1'b0;
        repeat (2) step();
        check("reset flags", {52'd0, postafull, postnempt, postovf}, 64'd0);
        check("reset out",   {11'd0, ififowr, ififodat, chkerr, errcnt[10:0]}, 64'd0);
        check("reset errcnt", 64'(errcnt), 64'd0);
        rst_n = 1'b1;
        step();

        // Three captures on channel 1, no drain.
        capture(2'd1, 36'hF_0000_0000);
        check("ch1 afull after 1", 64'(postafull), 64'h0);
        check("ch1 nempt after 1", 64'(postnempt), 64'h2);
        capture(2'd1, 36'hF_0000_0001);
        check("ch1 afull after 2", 64'(postafull), 64'h2);
        capture(2'd1, 36'hF_0000_0002);
        check("ch1 nempt after 3", 64'(postnempt), 64'h2);
        check("ch1 afull after 3", 64'(postafull), 64'h2);
        for (int i = 0; i < 3; i++) sb_q.push_back(36'hF_0000_0000 + 36'(i));
        drain(2'd1, 5);

        // Loop-back on channel 0: four beats, one cycle after the first pop.
        for (int i = 0; i < 4; i++) capture(2'd0, 36'hF_1000_0000 + 36'(i));
        for (int i = 0; i < 4; i++) sb_q.push_back(36'hF_1000_0000 + 36'(i));
        postchn = 2'd0;
        postena = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = ififowr;
        end
        postena = 1'b0;
        check("ch0 ififowr pattern", 64'(pat), 64'b011110);
        step();
        check("ch0 nempt fell", 64'(postnempt), 64'h0);

        // Overflow on channel 2.
        for (int i = 0; i < 5; i++) capture(2'd2, 36'hF_0000_0020 + 36'(i));
        check("ch2 ovf", 64'(postovf), 64'h4);
        check("ch2 afull full", 64'(postafull), 64'h4);
        for (int i = 0; i < 4; i++) sb_q.push_back(36'hF_0000_0020 + 36'(i));
        drain(2'd2, 6);
        check("ch2 drained", 64'(postnempt), 64'h0);

        // Channel 3: capture and pop together with two words held.
        capture(2'd3, 36'hF_A000_0000);
        capture(2'd3, 36'hF_A000_0001);
        for (int i = 0; i < 10; i++) sb_q.push_back(36'hF_A000_0000 + 36'(i));
        postchn = 2'd3;
        postena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            postdin = 36'hF_A000_0002 + 36'(i);
            rd_n    = 1'b0;
            rxf_n   = 1'b0;
            step();
        end
        rd_n  = 1'b1;
        rxf_n = 1'b1;
        check("ch3 len held afull", 64'(postafull), 64'h8);
        check("ch3 len held nempt", 64'(postnempt), 64'h8);
        repeat (4) step();
        postena = 1'b0;
        check("ch3 drained", 64'(postnempt), 64'h0);

        // Streaming check on channel 0: 0,1,5,6 -> one error, exp ends at 7.
        postmod = 1'b1;
        capture(2'd0, 36'hF_0000_0000);
        capture(2'd0, 36'hF_0000_0001);
        capture(2'd0, 36'hF_0000_0005);
        capture(2'd0, 36'hF_0000_0006);
        drain(2'd0, 6);
        check("stream chkerr", 64'(chkerr), 64'h1);
        check("stream errcnt", 64'(errcnt), 64'd1);
        capture(2'd0, 36'hF_0000_0007);
        drain(2'd0, 2);
        check("stream resync", 64'(errcnt), 64'd1);
        pulse_clr();
        check("clr chkerr", 64'(chkerr), 64'h0);
        check("clr errcnt", 64'(errcnt), 64'd0);
        check("clr ovf", 64'(postovf), 64'h0);
        capture(2'd0, 36'hF_0000_0000);
        drain(2'd0, 2);
        check("clr exp zero", 64'(errcnt), 64'd0);

        // Expected counter wraps through FFFFFFFF on channel 2.
        capture(2'd2, 36'hF_FFFF_FFFE);
        capture(2'd2, 36'hF_FFFF_FFFF);
        capture(2'd2, 36'hF_0000_0000);
        drain(2'd2, 5);
        check("wrap errcnt", 64'(errcnt), 64'd1);
        check("wrap chkerr", 64'(chkerr), 64'h4);
        pulse_clr();

        // Partial byte enables on an otherwise correct value.
        capture(2'd1, 36'h7_0000_0000);
        drain(2'd1, 3);
        check("be7 errcnt", 64'(errcnt), 64'd1);
        check("be7 chkerr", 64'(chkerr), 64'h2);

        // Reset in the middle of a transfer.
        postmod = 1'b0;
        capture(2'd3, 36'hF_0000_0100);
        capture(2'd3, 36'hF_0000_0101);
        check("pre-reset nempt", 64'(postnempt), 64'h8);
        postdin = 36'hF_0000_0102;
        rd_n    = 1'b0;
        rxf_n   = 1'b0;
        rst_n   = 1'b0;
        step();
        rd_n    = 1'b1;
        rxf_n   = 1'b1;
        check("midrst flags", {52'd0, postafull, postnempt, postovf}, 64'd0);
        check("midrst out",   {11'd0, ififowr, ififodat, chkerr, errcnt[10:0]}, 64'd0);
        check("midrst errcnt", 64'(errcnt), 64'd0);
        rst_n = 1'b1;
        step();
        check("post-reset empty", 64'(postnempt), 64'h0);

        // Clear coincident with a mismatch: clear wins.
        postmod = 1'b1;
        capture(2'd0, 36'hF_0000_0055);
        postchn = 2'd0;
        postena = 1'b1;
        chkclr  = 1'b1;
        step();
        postena = 1'b0;
        chkclr  = 1'b0;
        check("clr-vs-err chkerr", 64'(chkerr), 64'h0);
        check("clr-vs-err errcnt", 64'(errcnt), 64'd0);
        check("clr-vs-err popped", 64'(postnempt), 64'h0);

        repeat (3) step();
        check("scoreboard empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
